pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that supersedes the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width packed bundle of control and data fields from one stage to the next. It adds what the fixed latches lack: valid/ready flow control, hold (stall), synchronous flush that inserts a bubble, and an optional skid entry. The skid entry lets upstream see a registered ready without losing data.

---
 rtl/pipe_stage_reg.sv | 110 +++++++++++
 tb/tb_pipe_stage_reg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: carries a packed payload bundle between stages
// with valid/ready flow control, hold (stall), flush (bubble insertion) and
// an optional skid entry that keeps in_ready a registered signal.
module pipe_stage_reg #(
  parameter int               WIDTH  = 32,
  parameter bit               SKID   = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  logic             r_main_valid;
  logic [WIDTH-1:0] r_main_data;
  logic             r_skid_valid;
  logic             w_in_fire;
  logic             w_out_fire;

  // hold behaves exactly like a deasserted out_ready on the downstream side
  assign w_out_fire = r_main_valid & out_ready & ~hold;
  assign w_in_fire  = in_valid & in_ready;

  generate
    if (SKID) begin : g_skid
      logic [WIDTH-1:0] r_skid_data;

      // in_ready depends only on registered state, apart from the flush mask
      assign in_ready = ~r_skid_valid & ~flush;

      // Valid flags: EMPTY -> FULL1 -> FULL2 occupancy walk, cleared by reset or flush
      always_ff @(posedge CLK) begin
        if (!nRST) begin
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
        end else if (flush) begin
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
          // FULL2: draining main promotes the skid entry into main
          if (w_out_fire) begin
            r_skid_valid <= 1'b0;
          end
        end else if (r_main_valid) begin
          // FULL1: a lone out_fire empties, a lone in_fire spills into skid
          if (w_out_fire && !w_in_fire) begin
            r_main_valid <= 1'b0;
          end else if (!w_out_fire && w_in_fire) begin
            r_skid_valid <= 1'b1;
          end
        end else if (w_in_fire) begin
          r_main_valid <= 1'b1;
        end
      end

      // Payload registers load only when an entry is captured (no reset needed)
      always_ff @(posedge CLK) begin
        if (r_skid_valid) begin
          if (w_out_fire) begin
            r_main_data <= r_skid_data;
          end
        end else if (w_in_fire) begin
          if (r_main_valid && !w_out_fire) begin
            r_skid_data <= in_data;
          end else begin
            r_main_data <= in_data;
          end
        end
      end
    end else begin : g_noskid
      assign r_skid_valid = 1'b0;

      // Single entry: accept when empty or when the held payload leaves this cycle
      assign in_ready = (~r_main_valid | w_out_fire) & ~flush;

      // Main valid flag, cleared by reset or flush
      always_ff @(posedge CLK) begin
        if (!nRST) begin
          r_main_valid <= 1'b0;
        end else if (flush) begin
          r_main_valid <= 1'b0;
        end else if (w_in_fire) begin
          r_main_valid <= 1'b1;
        end else if (w_out_fire) begin
          r_main_valid <= 1'b0;
        end
      end

      // Main payload loads only on capture
      always_ff @(posedge CLK) begin
        if (w_in_fire) begin
          r_main_data <= in_data;
        end
      end
    end
  endgenerate

  assign out_valid = r_main_valid;
  assign out_data  = r_main_valid ? r_main_data : BUBBLE;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: one SKID=1 and one SKID=0 instance
// driven from hand-written vectors with hand-computed expectations.
module tb_pipe_stage_reg;

  logic        clk;
  logic        nrst;

  // SKID=1 instance signals
  logic        in_valid, in_ready, out_valid, out_ready, hold, flush;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;

  // SKID=0 instance signals
  logic        s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready, s0_hold, s0_flush;
  logic [31:0] s0_in_data, s0_out_data;
  logic [1:0]  s0_occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .BUBBLE(32'h0)) u_dut (
    .CLK(clk), .nRST(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .hold(hold), .flush(flush), .occupancy(occupancy)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .BUBBLE(32'h0)) u_dut0 (
    .CLK(clk), .nRST(nrst),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .hold(s0_hold), .flush(s0_flush), .occupancy(s0_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // advance one rising edge, then settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // check the SKID=1 instance outputs in one go
  task automatic check_state(input string tag, input logic v, input logic [31:0] d, input logic [1:0] occ);
    check_val({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    check_val({tag, ".data"},  out_data, d);
    check_val({tag, ".occ"},   {30'b0, occupancy}, {30'b0, occ});
  endtask

  initial begin
    nrst = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; hold = 1'b0; flush = 1'b0;
    s0_in_valid = 1'b0; s0_in_data = '0; s0_out_ready = 1'b0; s0_hold = 1'b0; s0_flush = 1'b0;

    // 1. reset then back-to-back stream
    tick(); tick();
    check_state("rst", 1'b0, 32'h0, 2'd0);
    check_val("rst.in_ready", {31'b0, in_ready}, 32'd1);
    check_val("rst.s0_in_ready", {31'b0, s0_in_ready}, 32'd1);
    nrst = 1'b1;
    in_valid = 1'b1; in_data = 32'h11;
    #1 check_val("t1.in_ready", {31'b0, in_ready}, 32'd1);
    tick(); check_state("t1.d11", 1'b1, 32'h11, 2'd1);
    in_data = 32'h22;
    tick(); check_state("t1.d22", 1'b1, 32'h22, 2'd1);
    in_data = 32'h33;
    tick(); check_state("t1.d33", 1'b1, 32'h33, 2'd1);
    in_valid = 1'b0;
    tick(); check_state("t1.empty", 1'b0, 32'h0, 2'd0);

    // 2. backpressure fills skid, then drains in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick(); check_state("t2.pushA", 1'b1, 32'hA, 2'd1);
    in_data = 32'hB;
    tick(); check_state("t2.pushB", 1'b1, 32'hA, 2'd2);
    in_data = 32'hC;
    #1 check_val("t2.in_ready_full", {31'b0, in_ready}, 32'd0);
    tick(); check_state("t2.heldC", 1'b1, 32'hA, 2'd2);
    out_ready = 1'b1;
    tick(); check_state("t2.outB", 1'b1, 32'hB, 2'd1);
    tick(); check_state("t2.outC", 1'b1, 32'hC, 2'd1);
    in_valid = 1'b0;
    tick(); check_state("t2.empty", 1'b0, 32'h0, 2'd0);

    // 3. hold overrides out_ready
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
    tick();
    in_valid = 1'b0; out_ready = 1'b1; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_state($sformatf("t3.hold%0d", i), 1'b1, 32'h5, 2'd1);
    end
    hold = 1'b0;
    tick(); check_state("t3.release", 1'b0, 32'h0, 2'd0);

    // 4. flush with full skid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick(); in_data = 32'hB;
    tick(); check_state("t4.full", 1'b1, 32'hA, 2'd2);
    in_data = 32'hC; flush = 1'b1;
    #1 check_val("t4.in_ready_flush", {31'b0, in_ready}, 32'd0);
    tick(); check_state("t4.flushed", 1'b0, 32'h0, 2'd0);
    flush = 1'b0;
    #1 check_val("t4.in_ready_after", {31'b0, in_ready}, 32'd1);
    tick(); check_state("t4.gotC", 1'b1, 32'hC, 2'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); check_state("t4.empty", 1'b0, 32'h0, 2'd0);

    // 6. mid-stream reset with full skid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    tick(); in_data = 32'h2;
    tick(); check_state("t6.full", 1'b1, 32'h1, 2'd2);
    in_valid = 1'b0; nrst = 1'b0;
    tick(); check_state("t6.rst", 1'b0, 32'h0, 2'd0);
    check_val("t6.in_ready", {31'b0, in_ready}, 32'd1);
    nrst = 1'b1; out_ready = 1'b1;
    tick(); check_state("t6.nostale", 1'b0, 32'h0, 2'd0);

    // 5. SKID=0 pass-through
    s0_out_ready = 1'b0; s0_in_valid = 1'b1; s0_in_data = 32'h1;
    tick();
    check_val("t5.s0_data1", s0_out_data, 32'h1);
    check_val("t5.s0_occ1", {30'b0, s0_occupancy}, 32'd1);
    s0_in_data = 32'h2;
    #1 check_val("t5.s0_in_ready_blocked", {31'b0, s0_in_ready}, 32'd0);
    s0_out_ready = 1'b1;
    #1 check_val("t5.s0_in_ready_pass", {31'b0, s0_in_ready}, 32'd1);
    tick();
    check_val("t5.s0_data2", s0_out_data, 32'h2);
    check_val("t5.s0_valid2", {31'b0, s0_out_valid}, 32'd1);
    s0_in_valid = 1'b0; s0_hold = 1'b1;
    #1 check_val("t5.s0_in_ready_hold", {31'b0, s0_in_ready}, 32'd0);
    tick();
    check_val("t5.s0_held", s0_out_data, 32'h2);
    s0_hold = 1'b0; s0_flush = 1'b1;
    #1 check_val("t5.s0_in_ready_flush", {31'b0, s0_in_ready}, 32'd0);
    tick();
    check_val("t5.s0_flushed_valid", {31'b0, s0_out_valid}, 32'd0);
    check_val("t5.s0_flushed_data", s0_out_data, 32'h0);
    check_val("t5.s0_flushed_occ", {30'b0, s0_occupancy}, 32'd0);
    s0_flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
